rv32_barrel_pc_unit: RTL and testbench

//   Multi-hart program-counter and fetch sequencer for the barrel-threaded pito core.

---
 rtl/rv32_barrel_pc_unit.sv | 86 ++++++++
 tb/tb_rv32_barrel_pc_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rv32_barrel_pc_unit.sv
// Barrel-threaded PC sequencer: one PC per hart, one round-robin fetch per cycle,
// with per-hart halt and single-port PC redirect from the writeback stage.
module rv32_barrel_pc_unit #(
    parameter int unsigned       NUM_HARTS   = 8,
    parameter int unsigned       PC_W        = 32,
    parameter int unsigned       IMEM_ADDR_W = 12,
    parameter logic [PC_W-1:0]   RESET_ADDR  = '0,
    parameter logic [PC_W-1:0]   HART_OFFSET = '0,
    localparam int unsigned      HID_W       = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
    input  logic                   rv32_io_clk,
    input  logic                   rv32_io_rst,
    input  logic                   rv32_io_run,
    input  logic [NUM_HARTS-1:0]   rv32_halt,
    input  logic                   rv32_redir_valid,
    input  logic [HID_W-1:0]       rv32_redir_hart,
    input  logic [PC_W-1:0]        rv32_redir_pc,
    output logic                   rv32_fetch_valid,
    output logic [HID_W-1:0]       rv32_fetch_hart,
    output logic [PC_W-1:0]        rv32_fetch_pc,
    output logic [IMEM_ADDR_W-1:0] rv32_imem_addr,
    output logic                   rv32_misalign,
    output logic [HID_W-1:0]       rv32_misalign_hart
);

    logic [PC_W-1:0]  pc_q [NUM_HARTS];
    logic [PC_W-1:0]  pc_d [NUM_HARTS];
    logic [HID_W-1:0] slot_q;
    logic [HID_W-1:0] slot_d;
    logic             issue_c;
    logic             redir_ok_c;
    logic             redir_mis_c;
    logic [PC_W-1:0]  slot_pc_c;

    // Next-state: a redirect to a hart overrides that hart's +4 in the same cycle.
    always_comb begin
        issue_c     = rv32_io_run && !rv32_halt[slot_q];
        redir_ok_c  = rv32_redir_valid && (32'(rv32_redir_hart) < NUM_HARTS);
        redir_mis_c = redir_ok_c && (rv32_redir_pc[1:0] != 2'b00);
        slot_pc_c   = pc_q[slot_q];
        slot_d      = slot_q;
        if (rv32_io_run) begin
            slot_d = (slot_q == HID_W'(NUM_HARTS - 1)) ? '0 : slot_q + HID_W'(1);
        end
        for (int unsigned h = 0; h < NUM_HARTS; h++) begin
            pc_d[h] = pc_q[h];
            if (redir_ok_c && (rv32_redir_hart == HID_W'(h))) begin
                pc_d[h] = {rv32_redir_pc[PC_W-1:2], 2'b00};
            end else if (issue_c && (slot_q == HID_W'(h))) begin
                pc_d[h] = pc_q[h] + PC_W'(4);
            end
        end
    end

    // State and registered fetch/misalign outputs; address fields hold while idle.
    always_ff @(posedge rv32_io_clk) begin
        if (rv32_io_rst) begin
            for (int unsigned h = 0; h < NUM_HARTS; h++) begin
                pc_q[h] <= RESET_ADDR + PC_W'(h) * HART_OFFSET;
            end
            slot_q             <= '0;
            rv32_fetch_valid   <= 1'b0;
            rv32_fetch_hart    <= '0;
            rv32_fetch_pc      <= '0;
            rv32_imem_addr     <= '0;
            rv32_misalign      <= 1'b0;
            rv32_misalign_hart <= '0;
        end else begin
            for (int unsigned h = 0; h < NUM_HARTS; h++) begin
                pc_q[h] <= pc_d[h];
            end
            slot_q           <= slot_d;
            rv32_fetch_valid <= issue_c;
            if (issue_c) begin
                rv32_fetch_hart <= slot_q;
                rv32_fetch_pc   <= slot_pc_c;
                rv32_imem_addr  <= slot_pc_c[IMEM_ADDR_W+1:2];
            end
            rv32_misalign <= redir_mis_c;
            if (redir_mis_c) begin
                rv32_misalign_hart <= rv32_redir_hart;
            end
        end
    end

endmodule

// File: tb/tb_rv32_barrel_pc_unit.sv
// Directed bench for rv32_barrel_pc_unit: 8-hart main instance plus a 5-hart
// instance for non-power-of-two rotation and out-of-range redirect.
module tb_rv32_barrel_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [7:0]  halt;
    logic        redir_valid;
    logic [2:0]  redir_hart;
    logic [31:0] redir_pc;
    logic        fetch_valid;
    logic [2:0]  fetch_hart;
    logic [31:0] fetch_pc;
    logic [11:0] imem_addr;
    logic        misalign;
    logic [2:0]  misalign_hart;

    logic [4:0]  halt5;
    logic        redir5_valid;
    logic [2:0]  redir5_hart;
    logic [31:0] redir5_pc;
    logic        fetch5_valid;
    logic [2:0]  fetch5_hart;
    logic [31:0] fetch5_pc;
    logic [11:0] imem5_addr;
    logic        misalign5;
    logic [2:0]  misalign5_hart;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_pc [8];
    int          m_slot;
    logic [2:0]  m_last_h;
    logic [31:0] m_last_pc;
    logic [2:0]  m_mis_h;

    always #5 clk = ~clk;

    rv32_barrel_pc_unit #(
        .NUM_HARTS(8), .PC_W(32), .IMEM_ADDR_W(12),
        .RESET_ADDR(32'h0), .HART_OFFSET(32'h100)
    ) u_dut (
        .rv32_io_clk(clk), .rv32_io_rst(rst), .rv32_io_run(run), .rv32_halt(halt),
        .rv32_redir_valid(redir_valid), .rv32_redir_hart(redir_hart), .rv32_redir_pc(redir_pc),
        .rv32_fetch_valid(fetch_valid), .rv32_fetch_hart(fetch_hart), .rv32_fetch_pc(fetch_pc),
        .rv32_imem_addr(imem_addr), .rv32_misalign(misalign), .rv32_misalign_hart(misalign_hart)
    );

    rv32_barrel_pc_unit #(
        .NUM_HARTS(5), .PC_W(32), .IMEM_ADDR_W(12),
        .RESET_ADDR(32'h0), .HART_OFFSET(32'h40)
    ) u_dut5 (
        .rv32_io_clk(clk), .rv32_io_rst(rst), .rv32_io_run(run), .rv32_halt(halt5),
        .rv32_redir_valid(redir5_valid), .rv32_redir_hart(redir5_hart), .rv32_redir_pc(redir5_pc),
        .rv32_fetch_valid(fetch5_valid), .rv32_fetch_hart(fetch5_hart), .rv32_fetch_pc(fetch5_pc),
        .rv32_imem_addr(imem5_addr), .rv32_misalign(misalign5), .rv32_misalign_hart(misalign5_hart)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int h = 0; h < 8; h++) m_pc[h] = 32'(h) * 32'h100;
        m_slot    = 0;
        m_last_h  = '0;
        m_last_pc = '0;
        m_mis_h   = '0;
    endtask

    // One clock: predict outputs from the inputs held across the edge, then compare.
    task automatic cyc();
        int         h;
        logic       exp_issue;
        logic       exp_ok;
        logic       exp_mis;
        h         = m_slot;
        exp_issue = run && !halt[h] && !rst;
        exp_ok    = !rst && redir_valid;
        exp_mis   = exp_ok && (redir_pc[1:0] != 2'b00);
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            if (exp_issue) begin
                m_last_h  = 3'(h);
                m_last_pc = m_pc[h];
                m_pc[h]   = m_pc[h] + 32'd4;
            end
            if (exp_ok) m_pc[redir_hart] = {redir_pc[31:2], 2'b00};
            if (exp_mis) m_mis_h = redir_hart;
            if (run) m_slot = (m_slot + 1) % 8;
        end
        chk("fetch_valid", 32'(fetch_valid), 32'(exp_issue));
        chk("fetch_hart", 32'(fetch_hart), 32'(m_last_h));
        chk("fetch_pc", fetch_pc, m_last_pc);
        chk("imem_addr", 32'(imem_addr), 32'(m_last_pc[13:2]));
        chk("misalign", 32'(misalign), 32'(exp_mis));
        if (exp_mis) chk("misalign_hart", 32'(misalign_hart), 32'(m_mis_h));
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; halt = '0;
        redir_valid = 1'b0; redir_hart = '0; redir_pc = '0;
        halt5 = '0; redir5_valid = 1'b0; redir5_hart = '0; redir5_pc = '0;
        model_reset();

        // Reset state
        cyc();
        cyc();
        chk("rst_misalign_hart", 32'(misalign_hart), 32'h0);

        // 1: startup rotation with per-hart reset stride
        rst = 1'b0; run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("t1_hart", 32'(fetch_hart), 32'(i));
            chk("t1_pc", fetch_pc, 32'(i) * 32'h100);
        end
        cyc();
        chk("t1_wrap_hart", 32'(fetch_hart), 32'h0);
        chk("t1_wrap_pc", fetch_pc, 32'h4);

        // 2: hart 2 halted for one rotation, then resumes at the same PC
        halt = 8'b0000_0100;
        cyc();
        cyc();
        chk("t2_halt_valid", 32'(fetch_valid), 32'h0);
        chk("t2_halt_hold_pc", fetch_pc, 32'h104);
        repeat (6) cyc();
        halt = '0;
        cyc();
        cyc();
        chk("t2_resume_hart", 32'(fetch_hart), 32'h2);
        chk("t2_resume_pc", fetch_pc, 32'h204);

        // 3: redirect hart 3 in the same cycle it issues
        redir_valid = 1'b1; redir_hart = 3'd3; redir_pc = 32'h2000;
        cyc();
        chk("t3_old_pc", fetch_pc, 32'h308);
        redir_valid = 1'b0;
        repeat (7) cyc();
        cyc();
        chk("t3_new_pc", fetch_pc, 32'h2000);
        repeat (7) cyc();
        cyc();
        chk("t3_next_pc", fetch_pc, 32'h2004);

        // 4: misaligned redirect of hart 1
        redir_valid = 1'b1; redir_hart = 3'd1; redir_pc = 32'h1002;
        cyc();
        chk("t4_mis", 32'(misalign), 32'h1);
        chk("t4_mis_hart", 32'(misalign_hart), 32'h1);
        redir_valid = 1'b0;
        cyc();
        chk("t4_mis_clear", 32'(misalign), 32'h0);
        repeat (3) cyc();
        cyc();
        chk("t4_hart", 32'(fetch_hart), 32'h1);
        chk("t4_pc", fetch_pc, 32'h1000);

        // Frozen sequencer still accepts a redirect
        run = 1'b0;
        redir_valid = 1'b1; redir_hart = 3'd4; redir_pc = 32'h4000;
        cyc();
        chk("frz_valid", 32'(fetch_valid), 32'h0);
        redir_valid = 1'b0;
        cyc();
        run = 1'b1;
        repeat (2) cyc();
        cyc();
        chk("frz_hart", 32'(fetch_hart), 32'h4);
        chk("frz_pc", fetch_pc, 32'h4000);

        // 5: PC wrap past 0xFFFF_FFFC
        redir_valid = 1'b1; redir_hart = 3'd5; redir_pc = 32'hFFFF_FFFC;
        cyc();
        redir_valid = 1'b0;
        repeat (7) cyc();
        cyc();
        chk("t5_top_pc", fetch_pc, 32'hFFFF_FFFC);
        chk("t5_top_imem", 32'(imem_addr), 32'hFFF);
        repeat (7) cyc();
        cyc();
        chk("t5_wrap_pc", fetch_pc, 32'h0);

        // 6: reset mid-rotation with a redirect pending
        redir_valid = 1'b1; redir_hart = 3'd2; redir_pc = 32'h5001;
        rst = 1'b1;
        cyc();
        chk("t6_valid", 32'(fetch_valid), 32'h0);
        chk("t6_pc", fetch_pc, 32'h0);
        chk("t6_mis", 32'(misalign), 32'h0);
        rst = 1'b0; redir_valid = 1'b0;
        // 5-hart instance sees an out-of-range redirect during its rotation
        redir5_valid = 1'b1; redir5_hart = 3'd6; redir5_pc = 32'h3003;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("n5_valid", 32'(fetch5_valid), 32'h1);
            chk("n5_hart", 32'(fetch5_hart), 32'(i % 5));
            chk("n5_pc", fetch5_pc, (i < 5) ? 32'(i) * 32'h40 : 32'h4);
            chk("n5_mis", 32'(misalign5), 32'h0);
            if (i == 2) chk("t6_hart2_pc", fetch_pc, 32'h200);
        end
        redir5_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
